// File: rtl/uart_mmio_port.sv
// Memory-stage engine for the memory-mapped UART: turns data/status register
// loads and stores into rdn/wrn strobes on the shared ram1 bus and stalls the pipeline meanwhile.
module uart_mmio_port #(
    parameter logic [15:0] DATA_ADDR = 16'hBF00,
    parameter logic [15:0] STAT_ADDR = 16'hBF01,
    parameter int          WRN_LOW   = 2,
    parameter int          RDN_LOW   = 2,
    parameter int          TIMEOUT   = 1023
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_read_i,
    input  logic        req_write_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic        hit_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        err_o,
    output logic        ram_disable_o,
    output logic [15:0] bus_out_o,
    output logic        bus_oe_o,
    input  logic [15:0] bus_in_i,
    output logic        rdn_o,
    output logic        wrn_o,
    input  logic        data_ready_i,
    input  logic        tbre_i,
    input  logic        tsre_i
);

    localparam int              WW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      WRN_LAST  = 4'(WRN_LOW - 1);
    localparam logic [3:0]      RDN_LAST  = 4'(RDN_LOW - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_WR_SETUP   = 4'd1;
    localparam logic [3:0] S_WR_PULSE   = 4'd2;
    localparam logic [3:0] S_WR_HOLD    = 4'd3;
    localparam logic [3:0] S_WR_WAIT_TB = 4'd4;
    localparam logic [3:0] S_WR_WAIT_TS = 4'd5;
    localparam logic [3:0] S_RD_WAIT    = 4'd6;
    localparam logic [3:0] S_RD_PULSE   = 4'd7;
    localparam logic [3:0] S_RD_RELEASE = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [3:0]    pulse_cnt_q, pulse_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [15:0]   bus_out_q, bus_out_d;
    logic          err_q, err_d;
    logic [1:0]    dr_sync_q, tbre_sync_q, tsre_sync_q;
    logic          dr_s, tbre_s, tsre_s;
    logic          unused_hi;

    assign dr_s      = dr_sync_q[1];
    assign tbre_s    = tbre_sync_q[1];
    assign tsre_s    = tsre_sync_q[1];
    assign unused_hi = ^{wdata_i[15:8], bus_in_i[15:8]};

    assign hit_o         = (addr_i == DATA_ADDR) || (addr_i == STAT_ADDR);
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign ram_disable_o = busy_o;
    assign bus_out_o     = bus_out_q;
    assign bus_oe_o      = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) || (state_q == S_WR_HOLD);
    // Strobes decode straight from state, so a timeout or reset releases them at once.
    assign wrn_o         = (state_q != S_WR_PULSE);
    assign rdn_o         = (state_q != S_RD_PULSE);

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        wait_cnt_d  = '0;
        rdata_d     = rdata_q;
        bus_out_d   = bus_out_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit_o && req_write_i) begin
                    if (addr_i == DATA_ADDR) begin
                        bus_out_d = {8'h00, wdata_i[7:0]};
                        state_d   = S_WR_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (hit_o && req_read_i) begin
                    if (addr_i == DATA_ADDR) begin
                        state_d = S_RD_WAIT;
                    end else begin
                        rdata_d = {14'b0, dr_s, tbre_s & tsre_s};
                        state_d = S_DONE;
                    end
                end
            end
            S_WR_SETUP: begin
                pulse_cnt_d = '0;
                state_d     = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (pulse_cnt_q == WRN_LAST) state_d = S_WR_HOLD;
                else                         pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
            // Wait states are skipped entirely when the transmitter is already idle.
            S_WR_HOLD: begin
                if (tbre_s && tsre_s) state_d = S_DONE;
                else if (tbre_s)      state_d = S_WR_WAIT_TS;
                else                  state_d = S_WR_WAIT_TB;
            end
            S_WR_WAIT_TB: begin
                if (tbre_s) begin
                    state_d = tsre_s ? S_DONE : S_WR_WAIT_TS;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WR_WAIT_TS: begin
                if (tsre_s) begin
                    state_d = S_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (dr_s) begin
                    pulse_cnt_d = '0;
                    state_d     = S_RD_PULSE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RD_PULSE: begin
                if (pulse_cnt_q == RDN_LAST) begin
                    rdata_d = {8'h00, bus_in_i[7:0]};
                    state_d = S_RD_RELEASE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            S_RD_RELEASE: state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pulse_cnt_q <= '0;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
            bus_out_q   <= '0;
            err_q       <= 1'b0;
            dr_sync_q   <= '0;
            tbre_sync_q <= '0;
            tsre_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rdata_q     <= rdata_d;
            bus_out_q   <= bus_out_d;
            err_q       <= err_d;
            dr_sync_q   <= {dr_sync_q[0], data_ready_i};
            tbre_sync_q <= {tbre_sync_q[0], tbre_i};
            tsre_sync_q <= {tsre_sync_q[0], tsre_i};
        end
    end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Directed + randomized bench for uart_mmio_port; expected cycle timelines are
// derived from the transfer rules with plain arithmetic per operation.
module tb_uart_mmio_port;

    localparam logic [15:0] DATA_A  = 16'hBF00;
    localparam logic [15:0] STAT_A  = 16'hBF01;
    localparam int          WRN_LOW = 2;
    localparam int          RDN_LOW = 2;
    localparam int          TIMEOUT = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_read_i, req_write_i;
    logic [15:0] addr_i, wdata_i, bus_in_i;
    logic        data_ready_i, tbre_i, tsre_i;
    logic        hit_o, busy_o, done_o, err_o, ram_disable_o, bus_oe_o, rdn_o, wrn_o;
    logic [15:0] rdata_o, bus_out_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] rdata_m;

    uart_mmio_port #(
        .DATA_ADDR(DATA_A), .STAT_ADDR(STAT_A),
        .WRN_LOW(WRN_LOW), .RDN_LOW(RDN_LOW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .hit_o(hit_o), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .ram_disable_o(ram_disable_o), .bus_out_o(bus_out_o), .bus_oe_o(bus_oe_o),
        .bus_in_i(bus_in_i), .rdn_o(rdn_o), .wrn_o(wrn_o),
        .data_ready_i(data_ready_i), .tbre_i(tbre_i), .tsre_i(tsre_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string p, input int k, input bit e_busy, input bit e_done,
                            input bit e_wrn, input bit e_rdn, input bit e_oe, input bit e_rdis,
                            input bit e_err);
        chk($sformatf("%s c%0d busy", p, k), {15'b0, busy_o}, {15'b0, e_busy});
        chk($sformatf("%s c%0d done", p, k), {15'b0, done_o}, {15'b0, e_done});
        chk($sformatf("%s c%0d wrn", p, k), {15'b0, wrn_o}, {15'b0, e_wrn});
        chk($sformatf("%s c%0d rdn", p, k), {15'b0, rdn_o}, {15'b0, e_rdn});
        chk($sformatf("%s c%0d bus_oe", p, k), {15'b0, bus_oe_o}, {15'b0, e_oe});
        chk($sformatf("%s c%0d ram_dis", p, k), {15'b0, ram_disable_o}, {15'b0, e_rdis});
        chk($sformatf("%s c%0d err", p, k), {15'b0, err_o}, {15'b0, e_err});
    endtask

    // tbre_at/tsre_at: cycle (relative to accept) at which the pin rises; <0 = already high, huge = never.
    task automatic data_write(input logic [15:0] wd, input int tbre_at, input int tsre_at);
        int    hold_c, tb_s, ts_s, t1, done_c;
        bit    tmo;
        string p;
        p = $sformatf("wr %04h tb%0d ts%0d", wd, tbre_at, tsre_at);
        tbre_i = (tbre_at < 0);
        tsre_i = (tsre_at < 0);
        repeat (3) tick();
        hold_c = 2 + WRN_LOW;
        tb_s   = (tbre_at < 0) ? 0 : tbre_at + 2;
        ts_s   = (tsre_at < 0) ? 0 : tsre_at + 2;
        tmo    = 1'b0;
        t1     = hold_c;
        done_c = 0;
        if (tb_s > hold_c + TIMEOUT) begin
            tmo    = 1'b1;
            done_c = hold_c + TIMEOUT + 1;
        end else if (tb_s > hold_c) begin
            t1 = tb_s;
        end
        if (!tmo) begin
            if (ts_s <= t1)                done_c = t1 + 1;
            else if (ts_s <= t1 + TIMEOUT) done_c = ts_s + 1;
            else begin
                tmo    = 1'b1;
                done_c = t1 + TIMEOUT + 1;
            end
        end
        addr_i      = DATA_A;
        wdata_i     = wd;
        req_write_i = 1'b1;
        if (tbre_at == 0) tbre_i = 1'b1;
        if (tsre_at == 0) tsre_i = 1'b1;
        #1 chk({p, " hit"}, {15'b0, hit_o}, 16'd1);
        for (int k = 1; k <= done_c + 1; k++) begin
            tick();
            req_write_i = 1'b0;
            chk_pins(p, k, k < done_c, k == done_c, !(k >= 2 && k <= 1 + WRN_LOW), 1'b1,
                     k >= 1 && k <= hold_c, k < done_c, tmo && k == done_c);
            if (k >= 1 && k <= hold_c) chk($sformatf("%s c%0d bus_out", p, k), bus_out_o, {8'h00, wd[7:0]});
            if (k == done_c) chk($sformatf("%s rdata", p), rdata_o, rdata_m);
            if (k == tbre_at) tbre_i = 1'b1;
            if (k == tsre_at) tsre_i = 1'b1;
            // A status read arriving mid-transfer must be ignored.
            req_read_i = (k == 2);
            if (k == 2) addr_i = STAT_A;
        end
        req_read_i = 1'b0;
        $display("[TB] data write %04h tbre_at=%0d tsre_at=%0d done@%0d err=%0d", wd, tbre_at, tsre_at, done_c, tmo);
    endtask

    task automatic data_read(input int dr_at, input logic [15:0] bin);
        int          dr_s, t, done_c;
        bit          tmo, rd_low;
        logic [15:0] exp;
        string       p;
        p = $sformatf("rd dr%0d", dr_at);
        data_ready_i = (dr_at < 0);
        bus_in_i     = bin;
        repeat (3) tick();
        dr_s = (dr_at < 0) ? 0 : dr_at + 2;
        t    = (dr_s < 1) ? 1 : dr_s;
        if (t <= TIMEOUT) begin
            tmo    = 1'b0;
            done_c = t + RDN_LOW + 2;
            exp    = {8'h00, bin[7:0]};
        end else begin
            tmo    = 1'b1;
            done_c = TIMEOUT + 1;
            exp    = 16'hFFFF;
        end
        addr_i     = DATA_A;
        req_read_i = 1'b1;
        if (dr_at == 0) data_ready_i = 1'b1;
        #1 chk({p, " hit"}, {15'b0, hit_o}, 16'd1);
        for (int k = 1; k <= done_c + 1; k++) begin
            tick();
            req_read_i = 1'b0;
            rd_low = !tmo && k > t && k <= t + RDN_LOW;
            chk_pins(p, k, k < done_c, k == done_c, 1'b1, !rd_low, 1'b0, k < done_c,
                     tmo && k == done_c);
            if (k >= done_c) chk($sformatf("%s c%0d rdata", p, k), rdata_o, exp);
            if (k == dr_at) data_ready_i = 1'b1;
        end
        rdata_m      = exp;
        data_ready_i = 1'b0;
        $display("[TB] data read dr_at=%0d bus_in=%04h rdata=%04h done@%0d err=%0d", dr_at, bin, exp, done_c, tmo);
    endtask

    task automatic status_op(input bit wr, input bit both, input bit dr, input bit tb, input bit ts);
        logic [15:0] exp;
        string       p;
        p = $sformatf("stat wr%0d both%0d", wr, both);
        data_ready_i = dr;
        tbre_i       = tb;
        tsre_i       = ts;
        repeat (3) tick();
        exp         = wr ? rdata_m : {14'b0, dr, tb & ts};
        addr_i      = STAT_A;
        req_write_i = wr;
        req_read_i  = !wr || both;
        #1 chk({p, " hit"}, {15'b0, hit_o}, 16'd1);
        tick();
        req_write_i = 1'b0;
        req_read_i  = 1'b0;
        chk_pins(p, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({p, " rdata"}, rdata_o, exp);
        rdata_m = exp;
        tick();
        chk_pins(p, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("[TB] status %s dr=%0d tbre=%0d tsre=%0d rdata=%04h", wr ? "write" : "read", dr, tb, ts, exp);
    endtask

    task automatic miss_op(input logic [15:0] a, input bit wr);
        string p;
        p = $sformatf("miss %04h", a);
        addr_i      = a;
        req_write_i = wr;
        req_read_i  = !wr;
        #1 chk({p, " hit"}, {15'b0, hit_o}, 16'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            req_write_i = 1'b0;
            req_read_i  = 1'b0;
            chk_pins(p, k, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk({p, " rdata"}, rdata_o, rdata_m);
        $display("[TB] miss %s addr=%04h ignored", wr ? "write" : "read", a);
    endtask

    initial begin
        logic [15:0] ra;
        int          tb_at, ts_at;
        rst_ni       = 1'b0;
        req_read_i   = 1'b0;
        req_write_i  = 1'b0;
        addr_i       = 16'h0000;
        wdata_i      = 16'h0000;
        bus_in_i     = 16'h0000;
        data_ready_i = 1'b0;
        tbre_i       = 1'b0;
        tsre_i       = 1'b0;
        rdata_m      = 16'h0000;
        repeat (2) tick();
        chk_pins("reset", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset bus_out", bus_out_o, 16'h0000);
        chk("reset rdata", rdata_o, 16'h0000);
        rst_ni = 1'b1;
        tick();
        $display("[TB] reset state checked");

        data_write(16'h1241, -3, -3);
        data_write(16'h7E33, 10, 14);
        data_read(6, 16'hAB5A);
        status_op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        data_read(1000000, 16'h1234);
        miss_op(16'h8000, 1'b0);
        data_write(16'h00F0, -3, 1000000);
        status_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        data_read(-3, 16'h00C7);

        // Reset while wrn is low, then a full write must run cleanly.
        tbre_i = 1'b1;
        tsre_i = 1'b1;
        repeat (3) tick();
        addr_i      = DATA_A;
        wdata_i     = 16'h00C3;
        req_write_i = 1'b1;
        tick();
        req_write_i = 1'b0;
        tick();
        chk("pre-rst wrn", {15'b0, wrn_o}, 16'd0);
        rst_ni = 1'b0;
        #1;
        chk_pins("rst mid", 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst mid bus_out", bus_out_o, 16'h0000);
        chk("rst mid rdata", rdata_o, 16'h0000);
        rdata_m = 16'h0000;
        tick();
        rst_ni = 1'b1;
        tick();
        $display("[TB] reset during wrn pulse checked");
        data_write(16'h5AA5, -3, -3);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    tb_at = ($urandom_range(0, 3) == 0) ? -3 : int'($urandom_range(0, 12));
                    ts_at = ($urandom_range(0, 3) == 0) ? -3 : int'($urandom_range(0, 14));
                    data_write(16'($urandom()), tb_at, ts_at);
                end
                1: begin
                    tb_at = ($urandom_range(0, 3) == 0) ? -3 : int'($urandom_range(0, 8));
                    data_read(tb_at, 16'($urandom()));
                end
                2: status_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
                default: begin
                    ra = 16'($urandom());
                    if (ra == DATA_A || ra == STAT_A) ra = 16'h8000;
                    miss_op(ra, 1'($urandom_range(0, 1)));
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
